mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Define MDU_EARLY_OUT_EN to finish trivial cases (x/0, overflow, mul by 0) in one edge.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] RUrs1,
  input  logic [31:0] RUrs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] MDUResult
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] res_q, res_d;

  logic        a_sgn, b_sgn;
  logic        sa, sb;
  logic        b_zero;
  logic [31:0] mag_a, mag_b;
  logic        eo_hit;
  logic [31:0] eo_res;

  logic [32:0] msum;
  logic [63:0] mul_nx;
  logic [32:0] rsh;
  logic [33:0] dtr;
  logic        ge;
  logic [63:0] div_nx;
  logic [63:0] step;
  logic [63:0] pm;
  logic [31:0] qs, rs;
  logic [31:0] fin;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
             (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) ||
             (funct3 == 3'b110);
    sa     = a_sgn & RUrs1[31];
    sb     = b_sgn & RUrs2[31];
    mag_a  = sa ? (~RUrs1 + 32'd1) : RUrs1;
    mag_b  = sb ? (~RUrs2 + 32'd1) : RUrs2;
    b_zero = (RUrs2 == 32'h0);
  end

`ifdef MDU_EARLY_OUT_EN
  logic ovf;

  always_comb begin
    ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
             (RUrs1 == 32'h8000_0000) &&
             (RUrs2 == 32'hFFFF_FFFF);
    eo_hit = 1'b0;
    eo_res = 32'h0;
    if (funct3[2]) begin
      eo_hit = b_zero | ovf;
      if (b_zero)
        eo_res = funct3[1] ? RUrs1 : 32'hFFFF_FFFF;
      else if (ovf)
        eo_res = funct3[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      eo_hit = (RUrs1 == 32'h0) | b_zero;
    end
  end
`else
  always_comb begin
    eo_hit = 1'b0;
    eo_res = 32'h0;
  end
`endif

  // One datapath iteration plus sign fix-up of the completed result
  always_comb begin
    msum   = {1'b0, acc_q[63:32]} +
             {1'b0, (acc_q[0] ? b_q : 32'h0)};
    mul_nx = {msum, acc_q[31:1]};
    rsh    = acc_q[63:31];
    dtr    = {1'b0, rsh} - {2'b00, b_q};
    ge     = ~dtr[33];
    div_nx = {(ge ? dtr[31:0] : rsh[31:0]),
              acc_q[30:0], ge};
    step   = op_q[2] ? div_nx : mul_nx;
    pm     = qneg_q ? (~step + 64'd1) : step;
    qs     = qneg_q ? (~step[31:0] + 32'd1) : step[31:0];
    rs     = rneg_q ? (~step[63:32] + 32'd1) : step[63:32];
    case (op_q)
      3'b000:                 fin = pm[31:0];
      3'b001, 3'b010, 3'b011: fin = pm[63:32];
      3'b100, 3'b101:         fin = qs;
      default:                fin = rs;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d   = funct3;
          acc_d  = {32'h0, mag_a};
          b_d    = mag_b;
          // x/0 quotient stays all-ones regardless of operand signs
          qneg_d = (sa ^ sb) & ~(funct3[2] & b_zero);
          rneg_d = sa;
          cnt_d  = 6'd0;
          if (eo_hit) begin
            state_d = DONE;
            res_d   = eo_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          res_d   = fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'h0;
      b_q     <= 32'h0;
      op_q    <= 3'b000;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign MDUResult = res_q;

endmodule
